seq_gen: RTL and testbench
==========================

SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 Parameter PAT_LEN, default 6, number of digits in one frame.
REQ-002 Parameter DW, default 4, digit width in bits.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request to begin a transmission; sampled in IDLE only.
REQ-006 abort  input  1  synchronous cancel of an active transmission.
REQ-007 frames  input  4  number of frames to send; captured at start; 0 treated as 1.
REQ-008 gap  input  4  filler digits inserted between consecutive frames; captured at start.
REQ-009 filler  input  DW  filler digit value; captured at start.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 out_data  output  DW  current digit.
REQ-012 out_valid  output  1  out_data is valid.
REQ-013 busy  output  1  high in SEND or GAP.
REQ-014 done  output  1  one-cycle pulse after last digit of last frame is accepted.

Function
REQ-015 Frame pattern SHALL be the fixed digit sequence 1,0,2,2,1,0 (index 0..5).
REQ-016 States SHALL be IDLE, SEND, GAP, with transitions only as listed below.
REQ-017 IDLE: start=1 -> capture frames/gap/filler, symbol index=0, frame count=0, go SEND next cycle.
REQ-018 First digit (1) SHALL appear on out_data with out_valid=1 in the cycle after start is sampled (latency 1).
REQ-019 A digit SHALL be consumed only on out_valid && out_ready; otherwise out_data and out_valid SHALL hold.
REQ-020 SEND: handshake at index<5 -> index+1; at index 5 -> frame count+1, index=0.
REQ-021 SEND, index 5 accepted, more frames remain, captured gap>0 -> GAP with gap counter=captured gap.
REQ-022 SEND, index 5 accepted, more frames remain, gap=0 -> stay SEND; next frame digit 1 directly follows, no bubble.
REQ-023 SEND, index 5 accepted, last frame -> IDLE, done=1 for exactly one cycle.
REQ-024 GAP: out_valid=1, out_data=filler digit; each handshake decrements gap counter; at 1 -> SEND, index=0.
REQ-025 Captured filler value 0, 1 or 2 SHALL be replaced by 4'hF so filler can never form part of the pattern.
REQ-026 abort=1 in SEND or GAP -> IDLE next cycle, out_valid=0, no done pulse; abort SHALL take priority over a simultaneous handshake.
REQ-027 start while busy SHALL be ignored; start and abort both high in IDLE -> stay IDLE.
REQ-028 out_valid=0 and out_data=0 in IDLE.
REQ-029 frames input changes after start SHALL NOT affect the active transmission.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, out_valid=0, out_data=0, busy=0, done=0, all counters 0.
REQ-031 Reset asserted mid-frame SHALL discard the transmission; after release no output until a new start.

Structure
REQ-032 Shared package seq_pkg SHALL hold the state encoding (IDLE, SEND, GAP), PAT_LEN, and the pattern digit constants.
REQ-033 One sub-module seq_rom SHALL map the 3-bit symbol index to the DW-bit pattern digit, combinationally.
REQ-034 Frame, symbol and gap counters plus the state register SHALL reside in seq_gen.

Verification
REQ-035 frames=1, gap=0, out_ready=1, pulse start -> out_data 1,0,2,2,1,0 on six consecutive cycles, done one cycle after last.
REQ-036 frames=2, gap=3, filler=9 -> 1,0,2,2,1,0,9,9,9,1,0,2,2,1,0; 15 handshakes; one done.
REQ-037 frames=1, out_ready toggled 0/1 each cycle -> each digit held stable until accepted; sequence unchanged.
REQ-038 frames=3, gap=0, output into existing detector fsm -> detector y asserts exactly 3 times.
REQ-039 filler=2, gap=2, frames=2 -> gap digits are F,F; abort during 4th digit -> out_valid=0 next cycle, no done.
REQ-040 rst_n pulled low mid-GAP -> outputs 0 immediately; start after release restarts at digit 1.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the framed digit-sequence generator.
// State encoding, frame length and the fixed frame pattern.
package seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam int PAT_LEN = 6;
    localparam int IDX_W   = 3;

    localparam int PAT_D0 = 1;
    localparam int PAT_D1 = 0;
    localparam int PAT_D2 = 2;
    localparam int PAT_D3 = 2;
    localparam int PAT_D4 = 1;
    localparam int PAT_D5 = 0;

    // Digits 0..2 occur in the pattern, so they are unsafe as filler.
    function automatic logic fill_unsafe(input int v);
        return v <= 2;
    endfunction

endpackage

// File: rtl/seq_gen_if.sv
// Valid/ready digit stream from the generator to its consumer.
// The generator is the master; the consumer owns out_ready.
interface seq_gen_if #(
    parameter int DW = 4
);
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/seq_rom.sv
// Combinational lookup of the frame pattern digit by symbol index.
// Indices past the frame length read as zero.
module seq_rom
    import seq_pkg::*;
#(
    parameter int DW = 4
) (
    input  logic [IDX_W-1:0] idx,
    output logic [DW-1:0]    digit
);

    always_comb begin
        digit = '0;
        unique case (idx)
            3'd0:    digit = DW'(PAT_D0);
            3'd1:    digit = DW'(PAT_D1);
            3'd2:    digit = DW'(PAT_D2);
            3'd3:    digit = DW'(PAT_D3);
            3'd4:    digit = DW'(PAT_D4);
            3'd5:    digit = DW'(PAT_D5);
            default: digit = '0;
        endcase
    end

endmodule

// File: rtl/seq_gen.sv
// Frame sequence generator: sends N pattern frames separated by
// filler digits over a valid/ready stream, with abort and done.
module seq_gen #(
    parameter int PAT_LEN = seq_pkg::PAT_LEN,
    parameter int DW      = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [3:0]    frames,
    input  logic [3:0]    gap,
    input  logic [DW-1:0] filler,
    seq_gen_if.master     bus,
    output logic          busy,
    output logic          done
);
    import seq_pkg::*;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(PAT_LEN - 1);

    state_t state_q, state_d;

    logic [IDX_W-1:0] idx_q;
    logic [3:0]       frm_cnt_q;
    logic [3:0]       frames_q;
    logic [3:0]       gap_q;
    logic [3:0]       gap_cnt_q;
    logic [DW-1:0]    fill_q;
    logic [DW-1:0]    rom_digit;
    logic             done_q;

    logic hs;
    logic last_sym;
    logic last_frm;
    logic go;

    assign hs       = bus.out_valid && bus.out_ready;
    assign last_sym = idx_q == LAST;
    assign last_frm = (frm_cnt_q + 4'd1) == frames_q;
    assign go       = start && !abort;
    assign done     = done_q;

    seq_rom #(.DW(DW)) u_rom (
        .idx   (idx_q),
        .digit (rom_digit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (go) state_d = S_SEND;
            end
            S_SEND: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (hs && last_sym) begin
                    if (last_frm)          state_d = S_IDLE;
                    else if (gap_q != '0)  state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (abort)
                    state_d = S_IDLE;
                else if (hs && gap_cnt_q == 4'd1)
                    state_d = S_SEND;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        busy          = 1'b0;
        unique case (state_q)
            S_SEND: begin
                bus.out_valid = 1'b1;
                bus.out_data  = rom_digit;
                busy          = 1'b1;
            end
            S_GAP: begin
                bus.out_valid = 1'b1;
                bus.out_data  = fill_q;
                busy          = 1'b1;
            end
            default: ;
        endcase
    end

    // Abort wins over a same-cycle handshake: nothing is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= '0;
            frm_cnt_q <= '0;
            frames_q  <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            fill_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (go) begin
                        frames_q  <= (frames == 4'd0) ? 4'd1 : frames;
                        gap_q     <= gap;
                        fill_q    <= fill_unsafe(int'(filler)) ? '1 : filler;
                        idx_q     <= '0;
                        frm_cnt_q <= '0;
                    end
                end
                S_SEND: begin
                    if (!abort && hs) begin
                        if (last_sym) begin
                            idx_q     <= '0;
                            frm_cnt_q <= frm_cnt_q + 4'd1;
                            gap_cnt_q <= gap_q;
                            done_q    <= last_frm;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (!abort && hs) begin
                        gap_cnt_q <= gap_cnt_q - 4'd1;
                        idx_q     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_gen.sv
// Randomized bench for seq_gen: expected digit stream built as a
// queue from frame/gap/filler rules, drained on each handshake.
module tb_seq_gen;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [3:0]    frames = '0;
    logic [3:0]    gap = '0;
    logic [DW-1:0] filler = '0;
    logic          busy;
    logic          done;

    seq_gen_if #(.DW(DW)) bus ();

    seq_gen #(.PAT_LEN(6), .DW(DW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .abort  (abort),
        .frames (frames),
        .gap    (gap),
        .filler (filler),
        .bus    (bus.master),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int pat[6]  = '{1, 0, 2, 2, 1, 0};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int count_pat(input int s[$]);
        int n = 0;
        for (int i = 0; i + 6 <= s.size(); i++) begin
            bit m = 1'b1;
            for (int k = 0; k < 6; k++)
                if (s[i+k] != pat[k]) m = 1'b0;
            if (m) n++;
        end
        return n;
    endfunction

    // mode: 0 ready always, 1 ready toggles, 2 ready random
    task automatic run_tx(input int fr, input int gp, input int fl,
                          input int mode, input int abort_at,
                          input int rst_at);
        logic [DW-1:0] q[$];
        int got[$];
        int nfr   = (fr == 0) ? 1 : fr;
        int fx    = (fl <= 2) ? 15 : fl;
        int total;
        int hs    = 0;
        int cyc   = 0;
        int dones = 0;
        bit want_done = 1'b0;
        bit aborted   = 1'b0;
        bit was_rst   = 1'b0;
        bit rdy;
        for (int f = 0; f < nfr; f++) begin
            for (int p = 0; p < 6; p++) q.push_back(DW'(pat[p]));
            if (f < nfr - 1)
                for (int g = 0; g < gp; g++) q.push_back(DW'(fx));
        end
        total = q.size();
        @(negedge clk);
        start  = 1'b1;
        frames = 4'(fr);
        gap    = 4'(gp);
        filler = DW'(fl);
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            start  = 1'b0;
            abort  = 1'b0;
            frames = 4'($urandom);
            gap    = 4'($urandom);
            filler = DW'($urandom);
            cyc++;
            if (done) dones++;
            if (cyc > 400) begin
                check("timeout", 32'(1), 32'(0));
                break;
            end
            if (aborted) begin
                check("abort_valid", 32'(bus.out_valid), 32'(0));
                check("abort_busy", 32'(busy), 32'(0));
                check("abort_done", 32'(done), 32'(0));
                break;
            end
            check("done", 32'(done), 32'(want_done));
            want_done = 1'b0;
            if (q.size() == 0) begin
                check("idle_valid", 32'(bus.out_valid), 32'(0));
                check("idle_data", 32'(bus.out_data), 32'(0));
                break;
            end
            check("valid", 32'(bus.out_valid), 32'(1));
            check("busy", 32'(busy), 32'(1));
            check("data", 32'(bus.out_data), 32'(q[0]));
            if (rst_at >= 0 && hs == rst_at) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_valid", 32'(bus.out_valid), 32'(0));
                check("rst_data", 32'(bus.out_data), 32'(0));
                check("rst_busy", 32'(busy), 32'(0));
                check("rst_done", 32'(done), 32'(0));
                @(negedge clk);
                rst_n = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    check("post_rst_valid", 32'(bus.out_valid), 32'(0));
                end
                was_rst = 1'b1;
                break;
            end
            unique case (mode)
                0:       rdy = 1'b1;
                1:       rdy = cyc[0];
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            bus.out_ready = rdy;
            if (mode == 2 && $urandom_range(0, 4) == 0) start = 1'b1;
            if (abort_at >= 0 && hs == abort_at) begin
                abort   = 1'b1;
                aborted = 1'b1;
            end else if (rdy) begin
                got.push_back(int'(bus.out_data));
                void'(q.pop_front());
                hs++;
                if (q.size() == 0) want_done = 1'b1;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        if (!was_rst) begin
            @(negedge clk);
            if (done) dones++;
            check("done_width", 32'(done), 32'(0));
            check("end_valid", 32'(bus.out_valid), 32'(0));
            check("done_count", 32'(dones), aborted ? 32'(0) : 32'(1));
            if (!aborted) begin
                check("hs_count", 32'(hs), 32'(total));
                check("frames_seen", 32'(count_pat(got)), 32'(nfr));
            end
        end
    endtask

    initial begin
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid0", 32'(bus.out_valid), 32'(0));
        check("rst_data0", 32'(bus.out_data), 32'(0));
        check("rst_busy0", 32'(busy), 32'(0));
        check("rst_done0", 32'(done), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_valid0", 32'(bus.out_valid), 32'(0));

        run_tx(1, 0, 5, 0, -1, -1);
        run_tx(2, 3, 9, 0, -1, -1);
        run_tx(1, 0, 7, 1, -1, -1);
        run_tx(3, 0, 7, 0, -1, -1);
        run_tx(2, 2, 2, 2, 3, -1);
        run_tx(2, 3, 9, 2, -1, 7);
        run_tx(1, 0, 5, 0, -1, -1);
        run_tx(0, 1, 1, 2, -1, -1);
        run_tx(2, 1, 0, 2, 7, -1);

        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_valid", 32'(bus.out_valid), 32'(0));
        check("start_abort_busy", 32'(busy), 32'(0));

        for (int i = 0; i < 20; i++) begin
            int ab = ($urandom_range(0, 3) == 0)
                   ? int'($urandom_range(0, 20)) : -1;
            run_tx(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                   ab, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
